// File: rtl/wash_sequencer.sv
// Washing-machine program sequencer: fill/wash/drain rounds, rinse/drain rounds, final spin,
// with pause/resume, soap-wait timeout, door-open abort and an exact remaining-time counter.
module wash_sequencer #(
  parameter int TW           = 8,
  parameter int FILL_T       = 8,
  parameter int WASH_T       = 12,
  parameter int DRAIN_T      = 8,
  parameter int RINSE_T      = 9,
  parameter int R_DRAIN_T    = 15,
  parameter int SPIN_T       = 12,
  parameter int WASH_CYCLES  = 2,
  parameter int RINSE_CYCLES = 2,
  parameter int SOAP_TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          power,
  input  logic          start,
  input  logic          pause,
  input  logic          doorclosed,
  input  logic          soap,
  input  logic [2:0]    program_selection,
  output logic          valve_in_cold,
  output logic          valve_in_hot,
  output logic          valve_out,
  output logic [1:0]    motor,
  output logic          soap_in,
  output logic          soap_warning,
  output logic          lockDoor,
  output logic          program_done,
  output logic          error,
  output logic [TW-1:0] remaining
);
  typedef enum logic [3:0] {
    S_IDLE, S_FILL, S_WAIT_SOAP, S_WASH, S_DRAIN_W, S_RINSE,
    S_DRAIN_R, S_SPIN, S_PAUSED, S_DONE, S_ABORT
  } state_t;

  localparam int TOTW = TW + 8;
  localparam logic [TOTW-1:0] SUM_SPIN  = TOTW'(SPIN_T);
  localparam logic [TOTW-1:0] SUM_RINSE = TOTW'(RINSE_CYCLES * (RINSE_T + R_DRAIN_T)) + SUM_SPIN;
  localparam logic [TOTW-1:0] SUM_WASH  = TOTW'(WASH_CYCLES * (FILL_T + WASH_T + DRAIN_T)) + SUM_RINSE;

  localparam logic [TW-1:0] L_FILL   = TW'(FILL_T - 1);
  localparam logic [TW-1:0] L_WASH   = TW'(WASH_T - 1);
  localparam logic [TW-1:0] L_DRAIN  = TW'(DRAIN_T - 1);
  localparam logic [TW-1:0] L_RINSE  = TW'(RINSE_T - 1);
  localparam logic [TW-1:0] L_RDRAIN = TW'(R_DRAIN_T - 1);
  localparam logic [TW-1:0] L_SPIN   = TW'(SPIN_T - 1);
  localparam logic [TW-1:0] L_SOAP   = TW'(SOAP_TIMEOUT - 1);
  localparam logic [TW-1:0] W_LAST   = TW'(WASH_CYCLES - 1);
  localparam logic [TW-1:0] R_LAST   = TW'(RINSE_CYCLES - 1);

  state_t          r_state;
  state_t          r_saved;
  logic [TW-1:0]   r_cnt;
  logic [TW-1:0]   r_rem;
  logic [TW-1:0]   r_wround;
  logic [TW-1:0]   r_rround;
  logic [2:0]      r_prog;

  logic            w_prog_ok;
  logic            w_is_wash;
  logic            w_door_abort;
  logic [TOTW-1:0] w_total_raw;
  logic [TW-1:0]   w_total;

  assign w_prog_ok = (program_selection <= 3'b100);
  assign w_is_wash = (program_selection == 3'b000) || (program_selection == 3'b001) ||
                     (program_selection == 3'b100);
  assign w_door_abort = !doorclosed && (r_state != S_IDLE) && (r_state != S_DONE);

  always_comb begin
    w_total_raw = SUM_SPIN;
    if (w_is_wash)
      w_total_raw = SUM_WASH;
    else if (program_selection == 3'b010)
      w_total_raw = SUM_RINSE;
  end

  assign w_total = (|w_total_raw[TOTW-1:TW]) ? '1 : w_total_raw[TW-1:0];

  always_ff @(posedge clk) begin
    if (!rst || !power) begin
      r_state  <= S_IDLE;
      r_saved  <= S_IDLE;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_wround <= '0;
      r_rround <= '0;
      r_prog   <= '0;
    end else if (w_door_abort) begin
      r_state <= S_ABORT;
      r_rem   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && doorclosed && w_prog_ok) begin
            r_prog   <= program_selection;
            r_rem    <= w_total;
            r_wround <= '0;
            r_rround <= '0;
            if (w_is_wash) begin
              r_state <= soap ? S_FILL : S_WAIT_SOAP;
              r_cnt   <= soap ? L_FILL : L_SOAP;
            end else if (program_selection == 3'b010) begin
              r_state <= S_RINSE;
              r_cnt   <= L_RINSE;
            end else begin
              r_state <= S_SPIN;
              r_cnt   <= L_SPIN;
            end
          end
        end
        // Soap arriving in the final wait cycle still wins over the timeout.
        S_WAIT_SOAP: begin
          if (soap) begin
            r_state <= S_FILL;
            r_cnt   <= L_FILL;
          end else if (r_cnt == '0) begin
            r_state <= S_ABORT;
            r_rem   <= '0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_PAUSED: if (!pause) r_state <= r_saved;
        S_DONE:   if (!doorclosed) r_state <= S_IDLE;
        S_ABORT:  if (start && doorclosed) r_state <= S_IDLE;
        S_FILL, S_WASH, S_DRAIN_W, S_RINSE, S_DRAIN_R, S_SPIN: begin
          if (pause) begin
            r_saved <= r_state;
            r_state <= S_PAUSED;
          end else begin
            r_rem <= r_rem - 1'b1;
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - 1'b1;
            end else begin
              case (r_state)
                S_FILL:  begin r_state <= S_WASH;    r_cnt <= L_WASH;   end
                S_WASH:  begin r_state <= S_DRAIN_W; r_cnt <= L_DRAIN;  end
                S_RINSE: begin r_state <= S_DRAIN_R; r_cnt <= L_RDRAIN; end
                S_DRAIN_W: begin
                  if (r_wround == W_LAST) begin
                    r_state <= S_RINSE;
                    r_cnt   <= L_RINSE;
                  end else begin
                    r_wround <= r_wround + 1'b1;
                    r_state  <= soap ? S_FILL : S_WAIT_SOAP;
                    r_cnt    <= soap ? L_FILL : L_SOAP;
                  end
                end
                S_DRAIN_R: begin
                  if (r_rround == R_LAST) begin
                    r_state <= S_SPIN;
                    r_cnt   <= L_SPIN;
                  end else begin
                    r_rround <= r_rround + 1'b1;
                    r_state  <= S_RINSE;
                    r_cnt    <= L_RINSE;
                  end
                end
                // A saturated total may not have counted down to zero by the end.
                default: begin
                  r_state <= S_DONE;
                  r_rem   <= '0;
                end
              endcase
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign valve_in_cold = ((r_state == S_FILL) && ((r_prog == 3'b000) || (r_prog == 3'b100))) ||
                         (r_state == S_RINSE);
  assign valve_in_hot  = (r_state == S_FILL) && ((r_prog == 3'b001) || (r_prog == 3'b100));
  assign valve_out     = (r_state == S_DRAIN_W) || (r_state == S_DRAIN_R);
  assign motor         = (r_state == S_WASH) ? 2'b01 : (r_state == S_SPIN) ? 2'b10 : 2'b00;
  assign soap_in       = (r_state == S_FILL);
  assign soap_warning  = (r_state == S_WAIT_SOAP);
  assign lockDoor      = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ABORT);
  assign program_done  = (r_state == S_DONE);
  assign error         = (r_state == S_ABORT);
  assign remaining     = r_rem;

endmodule
